microwave_cook_ctrl: RTL
========================

Name: microwave_cook_ctrl

Overview:
Sequential microwave cook controller that merges magnetron set/reset logic with an integrated BCD countdown timer and power-level duty cycling. It keeps the fixed safety priority: clear, stop and door-open override timer expiry, and timer expiry overrides start. The block sits between the debounced front-panel buttons or keypad latch and the magnetron driver and display.

Parameters:
DIGITS, 4, number of BCD digits in the cook time (pure decimal count, each digit 0-9).
TICK_DIV, 50_000_000, clk cycles per 1 s countdown tick (min 2).
POWER_LEVELS, 5, number of selectable power levels (min 1).
DUTY_PERIOD, 10, magnetron duty period in ticks; must be a multiple of POWER_LEVELS.
BEEP_TICKS, 3, beep duration in ticks (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startn  in  1  start button, active-low, synchronous to clk, debounced upstream
stopn  in  1  stop/pause button, active-low, synchronous, debounced
clearn  in  1  clear, active-low, level-sensitive
door_closed  in  1  1 = door closed
load  in  1  one-cycle pulse that latches preset_bcd
preset_bcd  in  4*DIGITS  preset time, BCD, most significant digit at MSBs
power_sel  in  $clog2(POWER_LEVELS) (min 1)  power level, 0 = lowest
mag_on  out  1  magnetron enable
remaining_bcd  out  4*DIGITS  remaining time
state_o  out  3  current state encoding
done  out  1  one-cycle pulse when the countdown reaches 0
beep  out  1  tone enable (tied 0 unless MWC_BEEP_EN is defined)

Behaviour:
- Reset values: state IDLE, remaining 0, prescaler 0, duty counter 0, mag_on 0, done 0, beep 0. Start and stop edge registers reset to 1 (inactive).
- Edges: start_ev is the falling edge of startn (registered previous value). stop_ev is the falling edge of stopn. clearn is a level input.
- States: IDLE=0, READY=1, COOK=2, PAUSE=3, DONE=4. Other encodings go to IDLE on the next cycle.
- Priority within a cycle: clear, then stop/door, then timer expiry, then start, then load.
- IDLE:
  - load: latch preset into remaining. Any digit greater than 9 is clamped to 9.
  - Nonzero remaining after load: go to READY. Zero: stay in IDLE.
- READY:
  - clearn=0: remaining←0, go to IDLE.
  - load: reload the preset.
  - start_ev with door_closed=1 and remaining≠0: go to COOK. On entry, prescaler←0, duty←0, and power_sel is sampled into the power register.
- COOK:
  - Prescaler counts 0..TICK_DIV-1. The tick fires when the prescaler equals TICK_DIV-1.
  - On a tick, remaining is decremented with BCD borrow, and duty advances, wrapping at DUTY_PERIOD-1.
  - If the decrement yields 0: go to DONE. done=1 on the cycle DONE is entered.
  - clearn=0: go to IDLE, remaining←0.
  - stop_ev or door_closed=0: go to PAUSE. Remaining, prescaler and duty are frozen.
  - load and power_sel changes are ignored.
- PAUSE:
  - start_ev with door closed: go to COOK, resuming the frozen prescaler and duty. power_sel is not resampled.
  - stop_ev or clearn=0: go to IDLE, remaining←0.
- DONE: lasts one cycle, then IDLE. Remaining stays 0.
- mag_on is registered and is 1 only when all of the following hold:
  - next state is COOK;
  - door_closed=1;
  - duty < (power+1)*DUTY_PERIOD/POWER_LEVELS.
  - At the top level (power=POWER_LEVELS-1) the magnetron is on continuously.
- mag_on drops to 0 on the first clock edge after door_closed falls. It is never 1 outside COOK.
- Simultaneous events:
  - Timer expiry and stop in the same cycle: go to PAUSE with remaining=1 (decrement suppressed).
  - start_ev and clearn=0 together: go to IDLE.
  - load and start_ev together in READY: start wins, and the old value is used.
- Asynchronous reset mid-cook forces mag_on=0 immediately.

Optional Feature:
MWC_BEEP_EN.
- Defined: entering DONE starts a beep counter. beep=1 for BEEP_TICKS ticks, counted with the free-running prescaler. The counter is cancelled by clearn=0 or start_ev.
- Undefined: beep is tied to 0 and no beep counter logic is synthesised.

Decomposition:
- Package mwc_pkg holds:
  - the state enum: IDLE, READY, COOK, PAUSE, DONE;
  - the state width constant, 3;
  - the BCD digit width constant, 4;
  - a function computing the on-threshold.
- Sub-module mwc_bcd_down_counter (parameter DIGITS) provides load, clamp, decrement-with-borrow and a zero flag.

Test Plan:
Use DIGITS=2, TICK_DIV=4, POWER_LEVELS=5, DUTY_PERIOD=10.
1. Load 0x03, start, door closed, power_sel=4 → mag_on=1 continuously; remaining 03→02→01→00 every 4 cycles; done pulses once; state returns to IDLE; mag_on=0.
2. Load 0x10, start; after one tick → remaining=0x09 (borrow). Open door → PAUSE, mag_on=0 next cycle, remaining holds 0x09. Close door and press start → resume.
3. power_sel=1 (on-threshold 4), remaining=0x20 → mag_on high 4 ticks and low 6 ticks, repeating.
4. Press stop in COOK → PAUSE; press stop again → IDLE with remaining=0x00. Also: clearn=0 while in COOK → IDLE within one cycle.
5. Load 0xA5 → remaining=0x95 (clamped). Load 0x00 → stays in IDLE. Start in IDLE → no effect.
6. Assert reset mid-COOK → mag_on=0 immediately, all outputs at reset values. With MWC_BEEP_EN defined, done → beep=1 for 12 cycles.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared types and helpers for the microwave cook controller.
// State encoding, BCD digit width and the magnetron on-threshold calculation.
package mwc_pkg;

  localparam int STATE_W = 3;
  localparam int BCD_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of duty slots per period during which the magnetron is on at a given power level.
  function automatic int on_threshold(input int power, input int duty_period, input int power_levels);
    return ((power + 1) * duty_period) / power_levels;
  endfunction

endpackage

// File: rtl/mwc_bcd_down_counter.sv
// Multi-digit BCD down counter: clamped preset load, decrement with borrow, zero flags.
// Priority of controls: clear, then load, then decrement.
module mwc_bcd_down_counter
  import mwc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic                    i_dec,
  input  logic [BCD_W*DIGITS-1:0] i_preset,
  output logic [BCD_W*DIGITS-1:0] o_value,
  output logic                    o_zero,
  output logic                    o_preset_zero,
  output logic                    o_dec_zero
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0] r_value;
  logic [W-1:0] w_clamped;
  logic [W-1:0] w_dec;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_clamped = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_clamped[d*BCD_W +: BCD_W] = (i_preset[d*BCD_W +: BCD_W] > 4'd9) ? 4'd9
                                                                      : i_preset[d*BCD_W +: BCD_W];
    end
  end

  always_comb begin
    logic w_borrow;
    w_dec    = r_value;
    w_borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_borrow) begin
        if (r_value[d*BCD_W +: BCD_W] == 4'd0) begin
          w_dec[d*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_dec[d*BCD_W +: BCD_W] = r_value[d*BCD_W +: BCD_W] - 4'd1;
          w_borrow                = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= w_clamped;
    end else if (i_dec) begin
      r_value <= w_dec;
    end
  end

  assign o_value       = r_value;
  assign o_zero        = (r_value == '0);
  assign o_preset_zero = (w_clamped == '0);
  assign o_dec_zero    = (w_dec == '0);

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook controller: safety-prioritised FSM, BCD countdown, power duty cycling.
// Optional beep after completion is enabled by defining MWC_BEEP_EN.
module microwave_cook_ctrl
  import mwc_pkg::*;
#(
  parameter  int DIGITS       = 4,
  parameter  int TICK_DIV     = 50_000_000,
  parameter  int POWER_LEVELS = 5,
  parameter  int DUTY_PERIOD  = 10,
  parameter  int BEEP_TICKS   = 3,
  localparam int PW           = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] preset_bcd,
  input  logic [PW-1:0]           power_sel,
  output logic                    mag_on,
  output logic [BCD_W*DIGITS-1:0] remaining_bcd,
  output logic [STATE_W-1:0]      state_o,
  output logic                    done,
  output logic                    beep
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DUTY_W = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(DUTY_PERIOD - 1);
  localparam logic [PW-1:0]     POWER_MAX = PW'(POWER_LEVELS - 1);

  if ((TICK_DIV < 2) || (POWER_LEVELS < 1) || ((DUTY_PERIOD % POWER_LEVELS) != 0) ||
      (BEEP_TICKS < 1)) begin : g_param_check
    $error("microwave_cook_ctrl: unsupported parameter combination");
  end

  state_e            r_state;
  state_e            w_state_nx;
  logic              r_startn_q;
  logic              r_stopn_q;
  logic [PRE_W-1:0]  r_pre;
  logic [PRE_W-1:0]  w_pre_nx;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] w_duty_nx;
  logic [PW-1:0]     r_power;
  logic [PW-1:0]     w_power_nx;
  logic [PW-1:0]     w_power_sat;
  logic              r_mag_on;
  logic              r_done;
  logic              w_mag_nx;

  logic w_start_ev;
  logic w_stop_ev;
  logic w_tick;
  logic w_cnt_clear;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_preset_zero;
  logic w_dec_zero;

  assign w_start_ev  = r_startn_q & ~startn;
  assign w_stop_ev   = r_stopn_q & ~stopn;
  assign w_tick      = (r_state == COOK) && (r_pre == PRE_LAST);
  assign w_power_sat = (power_sel > POWER_MAX) ? POWER_MAX : power_sel;

  mwc_bcd_down_counter #(
    .DIGITS (DIGITS)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_cnt_clear),
    .i_load        (w_cnt_load),
    .i_dec         (w_cnt_dec),
    .i_preset      (preset_bcd),
    .o_value       (remaining_bcd),
    .o_zero        (w_cnt_zero),
    .o_preset_zero (w_preset_zero),
    .o_dec_zero    (w_dec_zero)
  );

  // Each state tests its events in safety order: clear, stop/door, expiry, start, load.
  always_comb begin
    w_state_nx  = r_state;
    w_pre_nx    = r_pre;
    w_duty_nx   = r_duty;
    w_power_nx  = r_power;
    w_cnt_clear = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!clearn) begin
          w_cnt_clear = 1'b1;
        end else if (load) begin
          w_cnt_load = 1'b1;
          if (!w_preset_zero) w_state_nx = READY;
        end
      end
      READY: begin
        if (!clearn) begin
          w_cnt_clear = 1'b1;
          w_state_nx  = IDLE;
        end else if (w_start_ev && door_closed && !w_cnt_zero) begin
          w_state_nx = COOK;
          w_pre_nx   = '0;
          w_duty_nx  = '0;
          w_power_nx = w_power_sat;
        end else if (load) begin
          w_cnt_load = 1'b1;
          w_state_nx = w_preset_zero ? IDLE : READY;
        end
      end
      COOK: begin
        if (!clearn) begin
          w_cnt_clear = 1'b1;
          w_state_nx  = IDLE;
        end else if (w_stop_ev || !door_closed) begin
          w_state_nx = PAUSE;
        end else if (w_tick) begin
          w_cnt_dec = 1'b1;
          w_pre_nx  = '0;
          w_duty_nx = (r_duty == DUTY_LAST) ? '0 : r_duty + 1'b1;
          if (w_dec_zero) w_state_nx = DONE;
        end else begin
          w_pre_nx = r_pre + 1'b1;
        end
      end
      PAUSE: begin
        if (!clearn || w_stop_ev) begin
          w_cnt_clear = 1'b1;
          w_state_nx  = IDLE;
        end else if (w_start_ev && door_closed) begin
          w_state_nx = COOK;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_mag_nx = (w_state_nx == COOK) && door_closed &&
                    (int'(w_duty_nx) < on_threshold(int'(w_power_nx), DUTY_PERIOD, POWER_LEVELS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
      r_pre      <= '0;
      r_duty     <= '0;
      r_power    <= '0;
      r_mag_on   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_startn_q <= startn;
      r_stopn_q  <= stopn;
      r_pre      <= w_pre_nx;
      r_duty     <= w_duty_nx;
      r_power    <= w_power_nx;
      r_mag_on   <= w_mag_nx;
      r_done     <= (w_state_nx == DONE) && (r_state != DONE);
    end
  end

  assign mag_on  = r_mag_on;
  assign done    = r_done;
  assign state_o = r_state;

`ifdef MWC_BEEP_EN
  // The cook prescaler freezes outside COOK, so the beep keeps its own free-running one.
  localparam int BEEP_W = $clog2(BEEP_TICKS + 1);

  logic [BEEP_W-1:0] r_beep_cnt;
  logic [PRE_W-1:0]  r_beep_pre;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beep_cnt <= '0;
      r_beep_pre <= '0;
    end else if ((w_state_nx == DONE) && (r_state != DONE)) begin
      r_beep_cnt <= BEEP_W'(BEEP_TICKS);
      r_beep_pre <= '0;
    end else if (!clearn || w_start_ev) begin
      r_beep_cnt <= '0;
      r_beep_pre <= '0;
    end else if (r_beep_cnt != '0) begin
      if (r_beep_pre == PRE_LAST) begin
        r_beep_pre <= '0;
        r_beep_cnt <= r_beep_cnt - 1'b1;
      end else begin
        r_beep_pre <= r_beep_pre + 1'b1;
      end
    end
  end

  assign beep = (r_beep_cnt != '0);
`else
  assign beep = 1'b0;
`endif

endmodule
